dac_spi_output: RTL and testbench

- Downstream neighbour of the convolution filter stage.
- Takes each filtered 12-bit sample, queues it in a small FIFO, and serialises it to an external MCP4921-class 12-bit SPI DAC.
- After each frame it pulses LDAC so the analog output updates once per sample.
- Runs on the system clock; the sample strobe is synchronised internally.

---
 rtl/dac_pkg.sv | 28 ++
 rtl/sample_fifo.sv | 53 +++++
 rtl/dac_spi_output.sv | 160 ++++++++++++++++
 tb/tb_dac_spi_output.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared constants and types for the DAC SPI output stage.
// Sample width is shared with the upstream convolution filter stage.
package dac_pkg;

   localparam int SAMPLE_W   = 12;
   localparam int FRAME_BITS = 16;

   localparam logic CH_A   = 1'b0;
   localparam logic SHDN_N = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SHIFT,
      CS_HOLD,
      LDAC
   } state_t;

   // MCP4921 command word: channel, buffer, gain, shutdown, then data
   function automatic logic [FRAME_BITS-1:0] make_frame(
      input logic                buf_bit,
      input logic                ga_n,
      input logic [SAMPLE_W-1:0] sample
   );
      return {CH_A, buf_bit, ga_n, SHDN_N, sample};
   endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO with occupancy count.
// A push into a full FIFO succeeds only when a pop frees a slot that cycle.
module sample_fifo #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     resetN,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/dac_spi_output.sv
// Queues filtered samples and serialises them to an MCP4921-class SPI DAC,
// pulsing LDAC after every frame so the analog output updates per sample.
module dac_spi_output
   import dac_pkg::*;
#(
   parameter int CLK_DIV        = 4,
   parameter int FIFO_DEPTH     = 4,
   parameter int CS_IDLE_CYCLES = 2,
   parameter bit CFG_BUF        = 1'b0,
   parameter bit CFG_GA_N       = 1'b1
) (
   input  logic                          clk,
   input  logic                          resetN,
   input  logic [SAMPLE_W-1:0]           inSample,
   input  logic                          inSampleReady,
   input  logic                          enable,
   output logic                          dacCsN,
   output logic                          dacSck,
   output logic                          dacSdi,
   output logic                          dacLdacN,
   output logic                          busy,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifoLevel
);

   localparam int DIV_W    = $clog2(CLK_DIV) + 1;
   localparam int HOLD_C   = (CS_IDLE_CYCLES < 1) ? 1 : CS_IDLE_CYCLES;
   localparam int LDAC_C   = (CLK_DIV < 1) ? 1 : CLK_DIV;
   localparam int WAIT_MAX = (HOLD_C > LDAC_C) ? HOLD_C : LDAC_C;
   localparam int WAIT_W   = $clog2(WAIT_MAX) + 1;

   state_t state;
   state_t state_d;

   logic [2:0]            sync_q;
   logic                  rise;
   logic                  cap_vld;
   logic [SAMPLE_W-1:0]   cap_data;

   logic                  pop;
   logic [SAMPLE_W-1:0]   fifo_rd;
   logic                  fifo_full;
   logic                  fifo_empty;

   logic [FRAME_BITS-1:0] shreg;
   logic [DIV_W-1:0]      div_cnt;
   logic                  sck_hi;
   logic [4:0]            bit_cnt;
   logic [WAIT_W-1:0]     wait_cnt;
   logic                  div_end;
   logic                  last_bit;

   // sync_q[1] is the metastability-safe copy; sync_q[2] is its history
   assign rise = sync_q[1] & ~sync_q[2];

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         sync_q   <= '0;
         cap_vld  <= 1'b0;
         cap_data <= '0;
         overflow <= 1'b0;
      end else begin
         sync_q   <= {sync_q[1:0], inSampleReady};
         cap_vld  <= rise;
         if (rise) cap_data <= inSample;
         overflow <= cap_vld & fifo_full & ~pop;
      end
   end

   sample_fifo #(
      .WIDTH (SAMPLE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .resetN  (resetN),
      .push    (cap_vld),
      .wr_data (cap_data),
      .pop     (pop),
      .rd_data (fifo_rd),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifoLevel)
   );

   assign div_end  = (div_cnt == DIV_W'(CLK_DIV - 1));
   assign last_bit = (bit_cnt == 5'(FRAME_BITS - 1));

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) state <= IDLE;
      else         state <= state_d;
   end

   always_comb begin
      state_d = state;
      pop     = 1'b0;
      unique case (state)
         IDLE: begin
            if (enable && !fifo_empty) begin
               pop     = 1'b1;
               state_d = LOAD;
            end
         end
         LOAD: state_d = SHIFT;
         SHIFT: begin
            if (div_end && sck_hi && last_bit) state_d = CS_HOLD;
         end
         CS_HOLD: begin
            if (wait_cnt == WAIT_W'(HOLD_C - 1)) state_d = LDAC;
         end
         LDAC: begin
            if (wait_cnt == WAIT_W'(LDAC_C - 1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Shift happens at the end of each high phase, i.e. on SCK falling
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         shreg    <= '0;
         div_cnt  <= '0;
         sck_hi   <= 1'b0;
         bit_cnt  <= '0;
         wait_cnt <= '0;
      end else begin
         if (pop) begin
            shreg <= make_frame(CFG_BUF, CFG_GA_N, fifo_rd);
         end else if (state == SHIFT && div_end && sck_hi) begin
            shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
         end
         if (state == SHIFT) begin
            if (div_end) begin
               div_cnt <= '0;
               sck_hi  <= ~sck_hi;
               if (sck_hi) bit_cnt <= bit_cnt + 5'd1;
            end else begin
               div_cnt <= div_cnt + DIV_W'(1);
            end
         end else begin
            div_cnt <= '0;
            sck_hi  <= 1'b0;
            bit_cnt <= '0;
         end
         if (state_d != state) begin
            wait_cnt <= '0;
         end else if (state == CS_HOLD || state == LDAC) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
         end else begin
            wait_cnt <= '0;
         end
      end
   end

   assign busy     = (state != IDLE);
   assign dacCsN   = ~(state == LOAD || state == SHIFT);
   assign dacSck   = (state == SHIFT) & sck_hi;
   assign dacSdi   = (state == LOAD || state == SHIFT) & shreg[FRAME_BITS-1];
   assign dacLdacN = (state != LDAC);

endmodule

// File: tb/tb_dac_spi_output.sv
// Bench for dac_spi_output: an SPI receiver model decodes the DAC pins and
// the received words are compared with a queue of expected samples.
module tb_dac_spi_output;

   localparam int CLK_DIV    = 2;
   localparam int FIFO_DEPTH = 4;
   localparam int CS_IDLE    = 2;
   localparam int LW         = $clog2(FIFO_DEPTH) + 1;
   localparam int PERIOD     = 1 + 1 + 32 * CLK_DIV + CS_IDLE + CLK_DIV;

   logic          clk = 1'b0;
   logic          resetN = 1'b0;
   logic [11:0]   inSample = '0;
   logic          inSampleReady = 1'b0;
   logic          enable = 1'b0;
   logic          dacCsN;
   logic          dacSck;
   logic          dacSdi;
   logic          dacLdacN;
   logic          busy;
   logic          overflow;
   logic [LW-1:0] fifoLevel;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dac_spi_output #(
      .CLK_DIV        (CLK_DIV),
      .FIFO_DEPTH     (FIFO_DEPTH),
      .CS_IDLE_CYCLES (CS_IDLE),
      .CFG_BUF        (1'b0),
      .CFG_GA_N       (1'b1)
   ) dut (
      .clk           (clk),
      .resetN        (resetN),
      .inSample      (inSample),
      .inSampleReady (inSampleReady),
      .enable        (enable),
      .dacCsN        (dacCsN),
      .dacSck        (dacSck),
      .dacSdi        (dacSdi),
      .dacLdacN      (dacLdacN),
      .busy          (busy),
      .overflow      (overflow),
      .fifoLevel     (fifoLevel)
   );

   // DAC-side receiver model
   int          cyc = 0;
   logic        prev_csn = 1'b1;
   logic        prev_sck = 1'b0;
   logic        prev_ldac = 1'b1;
   logic        in_frame = 1'b0;
   logic [15:0] rx_word = '0;
   int          rx_bits = 0;
   int          cs_len = 0;
   int          ldac_len = 0;
   int          ov_cnt = 0;
   logic [15:0] rx_q[$];
   int          bits_q[$];
   int          len_q[$];
   int          start_q[$];
   int          ldac_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (prev_csn && !dacCsN) begin
         in_frame = 1'b1;
         rx_bits  = 0;
         rx_word  = '0;
         cs_len   = 0;
         start_q.push_back(cyc);
      end
      if (!dacCsN) begin
         cs_len++;
         if (!prev_sck && dacSck) begin
            rx_word = {rx_word[14:0], dacSdi};
            rx_bits++;
         end
      end
      if (!prev_csn && dacCsN && in_frame) begin
         rx_q.push_back(rx_word);
         bits_q.push_back(rx_bits);
         len_q.push_back(cs_len);
         in_frame = 1'b0;
      end
      if (!dacLdacN) ldac_len++;
      if (!prev_ldac && dacLdacN) begin
         ldac_q.push_back(ldac_len);
         ldac_len = 0;
      end
      if (overflow) ov_cnt++;
      prev_csn  = dacCsN;
      prev_sck  = dacSck;
      prev_ldac = dacLdacN;
   end

   function automatic logic [15:0] exp_frame(input logic [11:0] s);
      return {1'b0, 1'b0, 1'b1, 1'b1, s};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic strobe(input logic [11:0] s, input int hold, input int gap);
      inSample      = s;
      inSampleReady = 1'b1;
      tick(hold);
      inSampleReady = 1'b0;
      tick(gap);
   endtask

   task automatic wait_done(input int limit, input string tag);
      int k = 0;
      tick(5);
      while (!(busy === 1'b0 && fifoLevel == '0) && k < limit) begin
         tick(1);
         k++;
      end
      tick(3);
      chk({tag, "_timeout"}, 32'(k < limit), 1);
   endtask

   logic [11:0] exp_q[$];
   logic [11:0] s;
   int b_rx, b_st, b_ld, b_ov, lvl, exp_ov, k;

   initial begin
      tick(3);
      chk("rst_csn", dacCsN, 1);
      chk("rst_sck", dacSck, 0);
      chk("rst_sdi", dacSdi, 0);
      chk("rst_ldac", dacLdacN, 1);
      chk("rst_busy", busy, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_level", fifoLevel, 0);
      resetN = 1'b1;
      tick(2);

      // single sample frame
      enable = 1'b1;
      b_rx = rx_q.size();
      b_ld = ldac_q.size();
      strobe(12'hA5C, 2, 2);
      wait_done(400, "single");
      chk("single_count", rx_q.size() - b_rx, 1);
      chk("single_word", rx_q[b_rx], 16'h3A5C);
      chk("single_bits", bits_q[b_rx], 16);
      chk("single_cs_len", len_q[b_rx], 1 + 32 * CLK_DIV);
      chk("single_ldac", ldac_q[b_ld], CLK_DIV);
      chk("single_busy", busy, 0);
      chk("single_level", fifoLevel, 0);

      // burst of five while the first frame is in flight
      b_rx = rx_q.size();
      b_st = start_q.size();
      b_ov = ov_cnt;
      exp_q.delete();
      for (int i = 0; i < 5; i++) begin
         s = 12'($urandom);
         exp_q.push_back(s);
         strobe(s, 2, 2);
      end
      wait_done(1000, "burst");
      chk("burst_ovf", ov_cnt - b_ov, 0);
      chk("burst_count", rx_q.size() - b_rx, 5);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("burst_word%0d", i), rx_q[b_rx + i], exp_frame(exp_q[i]));
         chk($sformatf("burst_bits%0d", i), bits_q[b_rx + i], 16);
      end
      for (int i = 1; i < 5; i++)
         chk($sformatf("burst_period%0d", i),
             start_q[b_st + i] - start_q[b_st + i - 1], PERIOD);

      // overflow with the serialiser held off
      enable = 1'b0;
      b_rx = rx_q.size();
      b_ov = ov_cnt;
      exp_q.delete();
      lvl = 0;
      exp_ov = 0;
      for (int i = 0; i < 6; i++) begin
         s = 12'($urandom);
         if (lvl < FIFO_DEPTH) begin
            exp_q.push_back(s);
            lvl++;
         end else begin
            exp_ov++;
         end
         strobe(s, 2, 2);
      end
      tick(8);
      chk("ovf_level", fifoLevel, lvl);
      chk("ovf_pulses", ov_cnt - b_ov, exp_ov);
      chk("ovf_idle", rx_q.size() - b_rx, 0);
      enable = 1'b1;
      wait_done(1000, "ovf_drain");
      chk("ovf_count", rx_q.size() - b_rx, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         chk($sformatf("ovf_word%0d", i), rx_q[b_rx + i], exp_frame(exp_q[i]));

      // enable dropped mid-SHIFT
      b_rx = rx_q.size();
      b_st = start_q.size();
      b_ld = ldac_q.size();
      exp_q.delete();
      for (int i = 0; i < 2; i++) begin
         s = 12'($urandom);
         exp_q.push_back(s);
         strobe(s, 2, 2);
      end
      k = 0;
      while (dacCsN !== 1'b0 && k < 100) begin tick(1); k++; end
      chk("endrop_start", 32'(k < 100), 1);
      tick(20);
      enable = 1'b0;
      k = 0;
      while (ldac_q.size() == b_ld && k < 300) begin tick(1); k++; end
      chk("endrop_ldac_seen", 32'(k < 300), 1);
      tick(30);
      chk("endrop_count", rx_q.size() - b_rx, 1);
      chk("endrop_word", rx_q[b_rx], exp_frame(exp_q[0]));
      chk("endrop_ldac", ldac_q[b_ld], CLK_DIV);
      chk("endrop_starts", start_q.size() - b_st, 1);
      chk("endrop_busy", busy, 0);
      chk("endrop_level", fifoLevel, 1);
      enable = 1'b1;
      wait_done(400, "endrop_resume");
      chk("endrop_word2", rx_q[b_rx + 1], exp_frame(exp_q[1]));

      // reset in the middle of a frame
      b_st = start_q.size();
      strobe(12'($urandom), 2, 2);
      k = 0;
      while (!(in_frame && rx_bits == 7) && k < 300) begin tick(1); k++; end
      chk("rst_mid_reach", 32'(k < 300), 1);
      resetN = 1'b0;
      #1;
      chk("rst_mid_csn", dacCsN, 1);
      chk("rst_mid_sck", dacSck, 0);
      chk("rst_mid_sdi", dacSdi, 0);
      chk("rst_mid_ldac", dacLdacN, 1);
      chk("rst_mid_level", fifoLevel, 0);
      chk("rst_mid_busy", busy, 0);
      tick(3);
      resetN = 1'b1;
      tick(150);
      chk("rst_mid_nostart", start_q.size() - b_st, 1);
      chk("rst_mid_idle", busy, 0);

      // long strobe yields one sample
      b_rx = rx_q.size();
      b_ov = ov_cnt;
      s = 12'($urandom);
      strobe(s, 20, 2);
      wait_done(400, "long");
      chk("long_count", rx_q.size() - b_rx, 1);
      chk("long_word", rx_q[b_rx], exp_frame(s));
      chk("long_ovf", ov_cnt - b_ov, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
